rom_access_arbiter: RTL and testbench

ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

---
 rtl/rom_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rom_access_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// Two-lane round-robin arbiter in front of the C / Occ / read_and_D ROMs.
// A winning lookup is latched, issued to all three ROMs for one cycle,
// and after ROM_LAT cycles the ROM data is captured into a response that
// is held until the consumer accepts it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req0/req1; arbitrates and latches winner operands
// ISSUE | one cycle: gnt to the winner, all ROM enables high
// WAIT  | down-counter runs out the ROM latency, then captures ROM data
// RESP  | rsp_valid high, rsp_* frozen until rsp_ready is sampled
module rom_access_arbiter #(
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  i0,
    input  logic [7:0]  i1,
    input  logic [7:0]  k0,
    input  logic [7:0]  l0,
    input  logic [7:0]  k1,
    input  logic [7:0]  l1,
    input  logic [1:0]  sym0,
    input  logic [1:0]  sym1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ce_rom_C,
    output logic        ce_rom_Occ,
    output logic        ce_rom_read_and_D,
    output logic [1:0]  addr_rom_C,
    output logic [7:0]  addr1_rom_Occ,
    output logic [7:0]  addr2_rom_Occ,
    output logic [7:0]  addr_rom_read_and_D,
    input  logic [31:0] data,
    input  logic [31:0] data_1,
    input  logic [31:0] data_2,
    input  logic [7:0]  d_i,
    input  logic [1:0]  read_i,
    output logic        rsp_valid,
    output logic        rsp_id,
    input  logic        rsp_ready,
    output logic [31:0] rsp_C,
    output logic [31:0] rsp_occ1,
    output logic [31:0] rsp_occ2,
    output logic [7:0]  rsp_d,
    output logic [1:0]  rsp_read
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // WAIT loads ROM_LAT-1 and captures on terminal count zero.
    localparam logic [1:0] CNT_INIT = 2'(ROM_LAT - 1);

    logic [1:0] state;
    logic [1:0] cnt;
    logic       win_q;      // lane that owns the current transaction
    logic       last_gnt;   // lane granted most recently
    logic       ce_q;

    logic       win_id;
    logic [7:0] sel_i;
    logic [7:0] sel_k;
    logic [7:0] sel_l;
    logic [1:0] sel_sym;

    // Round-robin pick: on contention the lane not granted last wins.
    always_comb begin
        win_id = 1'b0;
        if (req0 && req1)
            win_id = ~last_gnt;
        else if (req1)
            win_id = 1'b1;
        sel_i   = win_id ? i1   : i0;
        sel_k   = win_id ? k1   : k0;
        sel_l   = win_id ? l1   : l0;
        sel_sym = win_id ? sym1 : sym0;
    end

    assign ce_rom_C          = ce_q;
    assign ce_rom_Occ        = ce_q;
    assign ce_rom_read_and_D = ce_q;

    // Sequencing FSM: grant/enable pulses, address latches, latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            cnt                 <= 2'd0;
            win_q               <= 1'b0;
            last_gnt            <= 1'b1;
            gnt0                <= 1'b0;
            gnt1                <= 1'b0;
            ce_q                <= 1'b0;
            addr_rom_C          <= 2'd0;
            addr1_rom_Occ       <= 8'd0;
            addr2_rom_Occ       <= 8'd0;
            addr_rom_read_and_D <= 8'd0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            ce_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state               <= ISSUE;
                        win_q               <= win_id;
                        gnt0                <= ~win_id;
                        gnt1                <= win_id;
                        ce_q                <= 1'b1;
                        addr_rom_C          <= sel_sym;
                        addr1_rom_Occ       <= sel_k;
                        addr2_rom_Occ       <= sel_l;
                        addr_rom_read_and_D <= sel_i;
                    end
                end
                ISSUE: begin
                    last_gnt <= win_q;
                    cnt      <= CNT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cnt == 2'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 2'd1;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response register: capture ROM data at terminal count, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_C     <= 32'd0;
            rsp_occ1  <= 32'd0;
            rsp_occ2  <= 32'd0;
            rsp_d     <= 8'd0;
            rsp_read  <= 2'd0;
        end else if (state == WAIT && cnt == 2'd0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win_q;
            rsp_C     <= data;
            rsp_occ1  <= data_1;
            rsp_occ2  <= data_2;
            rsp_d     <= d_i;
            rsp_read  <= read_i;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: one instance at ROM_LAT=1 and one
// at ROM_LAT=3 sharing the same stimulus.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  i0 = 8'd0, i1 = 8'd0, k0 = 8'd0, l0 = 8'd0, k1 = 8'd0, l1 = 8'd0;
    logic [1:0]  sym0 = 2'd0, sym1 = 2'd0;
    logic [31:0] data = 32'd0, data_1 = 32'd0, data_2 = 32'd0;
    logic [7:0]  d_i = 8'd0;
    logic [1:0]  read_i = 2'd0;
    logic        rsp_ready = 1'b0;

    logic        gnt0, gnt1, ce_c, ce_o, ce_r, rsp_valid, rsp_id;
    logic [1:0]  addr_c, rsp_read;
    logic [7:0]  addr_o1, addr_o2, addr_r, rsp_d;
    logic [31:0] rsp_C, rsp_occ1, rsp_occ2;

    logic        gnt0_3, gnt1_3, ce_c_3, ce_o_3, ce_r_3, rsp_valid_3, rsp_id_3;
    logic [1:0]  addr_c_3, rsp_read_3;
    logic [7:0]  addr_o1_3, addr_o2_3, addr_r_3, rsp_d_3;
    logic [31:0] rsp_C_3, rsp_occ1_3, rsp_occ2_3;

    int errors = 0;
    int checks = 0;

    rom_access_arbiter #(.ROM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .i0(i0), .i1(i1), .k0(k0), .l0(l0), .k1(k1), .l1(l1),
        .sym0(sym0), .sym1(sym1), .gnt0(gnt0), .gnt1(gnt1),
        .ce_rom_C(ce_c), .ce_rom_Occ(ce_o), .ce_rom_read_and_D(ce_r),
        .addr_rom_C(addr_c), .addr1_rom_Occ(addr_o1), .addr2_rom_Occ(addr_o2),
        .addr_rom_read_and_D(addr_r), .data(data), .data_1(data_1), .data_2(data_2),
        .d_i(d_i), .read_i(read_i), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .rsp_C(rsp_C), .rsp_occ1(rsp_occ1), .rsp_occ2(rsp_occ2),
        .rsp_d(rsp_d), .rsp_read(rsp_read)
    );

    rom_access_arbiter #(.ROM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .i0(i0), .i1(i1), .k0(k0), .l0(l0), .k1(k1), .l1(l1),
        .sym0(sym0), .sym1(sym1), .gnt0(gnt0_3), .gnt1(gnt1_3),
        .ce_rom_C(ce_c_3), .ce_rom_Occ(ce_o_3), .ce_rom_read_and_D(ce_r_3),
        .addr_rom_C(addr_c_3), .addr1_rom_Occ(addr_o1_3), .addr2_rom_Occ(addr_o2_3),
        .addr_rom_read_and_D(addr_r_3), .data(data), .data_1(data_1), .data_2(data_2),
        .d_i(d_i), .read_i(read_i), .rsp_valid(rsp_valid_3), .rsp_id(rsp_id_3),
        .rsp_ready(rsp_ready), .rsp_C(rsp_C_3), .rsp_occ1(rsp_occ1_3), .rsp_occ2(rsp_occ2_3),
        .rsp_d(rsp_d_3), .rsp_read(rsp_read_3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        data = 32'h1234_5678; data_1 = 32'h9ABC_DEF0; data_2 = 32'h0F0F_0F0F;
        d_i = 8'hA5; read_i = 2'd2;
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt got=%b exp=00", {gnt0, gnt1});
        end
        checks++;
        if ({ce_c, ce_o, ce_r} !== 3'b000) begin
            errors++; $display("FAIL reset_ce got=%b exp=000", {ce_c, ce_o, ce_r});
        end
        checks++;
        if ({addr_c, addr_o1, addr_o2, addr_r} !== 26'd0) begin
            errors++; $display("FAIL reset_addr got=%h exp=0", {addr_c, addr_o1, addr_o2, addr_r});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read} !== 108'd0) begin
            errors++; $display("FAIL reset_rsp got valid=%b id=%b C=%h", rsp_valid, rsp_id, rsp_C);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_lookup();
        rsp_ready = 1'b1;
        req0 = 1'b1; i0 = 8'h05; k0 = 8'h10; l0 = 8'h2A; sym0 = 2'd2;
        data = 32'hC0DE_0001; data_1 = 32'hC0DE_0002; data_2 = 32'hC0DE_0003;
        d_i = 8'h5A; read_i = 2'd1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL single_gnt got=%b exp=10", {gnt0, gnt1});
        end
        checks++;
        if ({ce_c, ce_o, ce_r} !== 3'b111) begin
            errors++; $display("FAIL single_ce got=%b exp=111", {ce_c, ce_o, ce_r});
        end
        checks++;
        if ({addr_c, addr_o1, addr_o2, addr_r} !== {2'd2, 8'h10, 8'h2A, 8'h05}) begin
            errors++; $display("FAIL single_addr got=%h exp=%h",
                {addr_c, addr_o1, addr_o2, addr_r}, {2'd2, 8'h10, 8'h2A, 8'h05});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, ce_c, ce_o, ce_r, rsp_valid} !== 6'd0) begin
            errors++; $display("FAIL single_wait got=%b exp=000000",
                {gnt0, gnt1, ce_c, ce_o, ce_r, rsp_valid});
        end
        checks++;
        if (addr_r !== 8'h05) begin
            errors++; $display("FAIL single_addr_hold got=%h exp=05", addr_r);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id} !== 2'b10) begin
            errors++; $display("FAIL single_rsp_valid got=%b exp=10", {rsp_valid, rsp_id});
        end
        checks++;
        if ({rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read} !==
            {32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 8'h5A, 2'd1}) begin
            errors++; $display("FAIL single_rsp_data got C=%h o1=%h o2=%h d=%h r=%h",
                rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [3:0] seq = 4'd0;
        int ng = 0;
        int dbl = 0;
        int bad_addr = 0;
        do_reset();
        rsp_ready = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        i0 = 8'h11; i1 = 8'h22;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (gnt0 && gnt1) dbl++;
            if (gnt0 || gnt1) begin
                ng++;
                seq = {seq[2:0], gnt1};
                if (addr_r !== (gnt1 ? 8'h22 : 8'h11)) bad_addr++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (ng !== 4) begin
            errors++; $display("FAIL contention_count got=%0d exp=4", ng);
        end
        checks++;
        if (seq !== 4'b0101) begin
            errors++; $display("FAIL contention_order got=%b exp=0101", seq);
        end
        checks++;
        if (dbl !== 0) begin
            errors++; $display("FAIL contention_double got=%0d exp=0", dbl);
        end
        checks++;
        if (bad_addr !== 0) begin
            errors++; $display("FAIL contention_addr got=%0d exp=0", bad_addr);
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        rsp_ready = 1'b0;
        req0 = 1'b1; i0 = 8'h33; k0 = 8'h44; l0 = 8'h55; sym0 = 2'd1;
        data = 32'hAAAA_0001; data_1 = 32'hBBBB_0002; data_2 = 32'hCCCC_0003;
        d_i = 8'h7E; read_i = 2'd3;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL bp_gnt got=%b exp=10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_C, rsp_d} !== {2'b10, 32'hAAAA_0001, 8'h7E}) begin
            errors++; $display("FAIL bp_rsp got valid=%b id=%b C=%h d=%h", rsp_valid, rsp_id, rsp_C, rsp_d);
        end
        data = 32'hDEAD_BEEF; data_1 = 32'h0; data_2 = 32'h1; d_i = 8'h00; read_i = 2'd0;
        req1 = 1'b1; i1 = 8'h9A; k1 = 8'h01; l1 = 8'h02; sym1 = 2'd3;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rsp_valid !== 1'b1) bad++;
            if ({rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read} !==
                {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 8'h7E, 2'd3}) bad++;
            if ({ce_c, ce_o, ce_r, gnt0, gnt1} !== 5'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold got=%0d violations exp=0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, gnt1} !== 2'b00) begin
            errors++; $display("FAIL bp_handshake got=%b exp=00", {rsp_valid, gnt1});
        end
        tick();
        checks++;
        if ({gnt0, gnt1, addr_r} !== {2'b01, 8'h9A}) begin
            errors++; $display("FAIL bp_req1_after got=%b addr=%h exp=01 addr=9a", {gnt0, gnt1}, addr_r);
        end
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_C} !== {2'b11, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL bp_req1_rsp got valid=%b id=%b C=%h", rsp_valid, rsp_id, rsp_C);
        end
        tick();
    endtask

    task automatic test_lat3();
        do_reset();
        rsp_ready = 1'b0;
        req0 = 1'b1; i0 = 8'h66; k0 = 8'h77; l0 = 8'h88; sym0 = 2'd3;
        data = 32'h0BAD_0000; data_1 = 32'h0BAD_1000; data_2 = 32'h0BAD_2000;
        d_i = 8'hF0; read_i = 2'd0;
        tick();
        checks++;
        if ({gnt0_3, gnt1_3, ce_c_3, ce_o_3, ce_r_3} !== 5'b10111) begin
            errors++; $display("FAIL lat3_issue got=%b exp=10111", {gnt0_3, gnt1_3, ce_c_3, ce_o_3, ce_r_3});
        end
        checks++;
        if ({addr_c_3, addr_o1_3, addr_o2_3, addr_r_3} !== {2'd3, 8'h77, 8'h88, 8'h66}) begin
            errors++; $display("FAIL lat3_addr got=%h", {addr_c_3, addr_o1_3, addr_o2_3, addr_r_3});
        end
        req0 = 1'b0;
        tick();
        data = 32'h0BAD_0001; data_1 = 32'h0BAD_1001; d_i = 8'hF1;
        checks++;
        if (rsp_valid_3 !== 1'b0) begin
            errors++; $display("FAIL lat3_early1 got=%b exp=0", rsp_valid_3);
        end
        tick();
        data = 32'h0BAD_0002; data_1 = 32'h0BAD_1002; d_i = 8'hF2;
        checks++;
        if (rsp_valid_3 !== 1'b0) begin
            errors++; $display("FAIL lat3_early2 got=%b exp=0", rsp_valid_3);
        end
        tick();
        data = 32'h600D_0003; data_1 = 32'h600D_1003; data_2 = 32'h600D_2003;
        d_i = 8'h3C; read_i = 2'd1;
        checks++;
        if (rsp_valid_3 !== 1'b0) begin
            errors++; $display("FAIL lat3_early3 got=%b exp=0", rsp_valid_3);
        end
        tick();
        data = 32'hFFFF_FFFF; d_i = 8'hFF;
        checks++;
        if ({rsp_valid_3, rsp_id_3} !== 2'b10) begin
            errors++; $display("FAIL lat3_valid got=%b exp=10", {rsp_valid_3, rsp_id_3});
        end
        checks++;
        if ({rsp_C_3, rsp_occ1_3, rsp_occ2_3, rsp_d_3, rsp_read_3} !==
            {32'h600D_0003, 32'h600D_1003, 32'h600D_2003, 8'h3C, 2'd1}) begin
            errors++; $display("FAIL lat3_data got C=%h o1=%h o2=%h d=%h r=%h",
                rsp_C_3, rsp_occ1_3, rsp_occ2_3, rsp_d_3, rsp_read_3);
        end
        tick();
        tick();
        checks++;
        if ({rsp_valid_3, rsp_C_3} !== {1'b1, 32'h600D_0003}) begin
            errors++; $display("FAIL lat3_hold got valid=%b C=%h", rsp_valid_3, rsp_C_3);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid_3 !== 1'b0) begin
            errors++; $display("FAIL lat3_drop got=%b exp=0", rsp_valid_3);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        rsp_ready = 1'b1;
        req0 = 1'b1; i0 = 8'h42; k0 = 8'h43; l0 = 8'h44; sym0 = 2'd1;
        tick();
        req0 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, ce_c, ce_o, ce_r, addr_c, addr_o1, addr_o2, addr_r} !== 31'd0) begin
            errors++; $display("FAIL midrst_ctrl got addr=%h", {addr_c, addr_o1, addr_o2, addr_r});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read} !== 108'd0) begin
            errors++; $display("FAIL midrst_rsp got valid=%b C=%h", rsp_valid, rsp_C);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if ({gnt0, gnt1, rsp_valid, ce_c} !== 4'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midrst_quiet got=%0d violations exp=0", bad);
        end
        req1 = 1'b1; i1 = 8'h9A; k1 = 8'hBC; l1 = 8'hDE; sym1 = 2'd2;
        data = 32'h1111_2222; data_1 = 32'h3333_4444; data_2 = 32'h5555_6666;
        d_i = 8'h77; read_i = 2'd2;
        tick();
        checks++;
        if ({gnt0, gnt1, ce_c, ce_o, ce_r} !== 5'b01111) begin
            errors++; $display("FAIL midrst_gnt1 got=%b exp=01111", {gnt0, gnt1, ce_c, ce_o, ce_r});
        end
        checks++;
        if ({addr_c, addr_o1, addr_o2, addr_r} !== {2'd2, 8'hBC, 8'hDE, 8'h9A}) begin
            errors++; $display("FAIL midrst_addr got=%h", {addr_c, addr_o1, addr_o2, addr_r});
        end
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_id} !== 2'b11) begin
            errors++; $display("FAIL midrst_rsp_id got=%b exp=11", {rsp_valid, rsp_id});
        end
        checks++;
        if ({rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read} !==
            {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 8'h77, 2'd2}) begin
            errors++; $display("FAIL midrst_rsp_data got C=%h o1=%h o2=%h d=%h r=%h",
                rsp_C, rsp_occ1, rsp_occ2, rsp_d, rsp_read);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_drop got=%b exp=0", rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_lookup();
        test_contention();
        test_backpressure();
        test_lat3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
